// File: rtl/rc4_arbiter.sv
// rtl/rc4_arbiter.sv - two-requester session arbiter in front of an RC4 engine
// Optional engine watchdog enabled by defining RC4_ARB_TIMEOUT_EN.
module rc4_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [7:0] len_a,
    input  logic [7:0] len_b,
    input  logic [7:0] key_a,
    input  logic [7:0] key_b,
    input  logic [7:0] din_a,
    input  logic [7:0] din_b,
    input  logic       din_valid_a,
    input  logic       din_valid_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [4:0] key_addr,
    output logic       din_ack,
    output logic [7:0] dout_a,
    output logic [7:0] dout_b,
    output logic       dout_valid_a,
    output logic       dout_valid_b,
    output logic       done_a,
    output logic       done_b,
    output logic       err,
    output logic       core_rst,
    output logic       key_valid,
    output logic [7:0] key_in,
    output logic       plain_in_valid,
    output logic [7:0] plain_in,
    input  logic       plain_read,
    input  logic       cipher_write,
    input  logic [7:0] cipher_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_KEY, S_KSA, S_DATA, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;   // 0 = A, 1 = B
    logic       prio_q, prio_d;     // requester preferred on a tie
    logic [7:0] len_q, len_d;
    logic [7:0] sent_q, sent_d;
    logic [7:0] recv_q, recv_d;
    logic [5:0] key_cnt_q, key_cnt_d;
    logic [7:0] dout_a_q, dout_a_d;
    logic [7:0] dout_b_q, dout_b_d;
    logic       dva_q, dva_d;
    logic       dvb_q, dvb_d;
    logic       timeout;

    logic [7:0] own_din;
    logic       own_dv;
    logic [7:0] own_key;
    logic       beat;
    logic       capture;

    assign own_din = owner_q ? din_b : din_a;
    assign own_dv  = owner_q ? din_valid_b : din_valid_a;
    assign own_key = owner_q ? key_b : key_a;
    assign beat    = (state_q == S_DATA) && own_dv && plain_read && (sent_q < len_q);
    assign capture = ((state_q == S_DATA) || (state_q == S_DRAIN)) && cipher_write;

`ifdef RC4_ARB_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = 8'd0;
        if ((state_q == S_KSA) || (state_q == S_DRAIN))
            wdog_d = wdog_q + 8'd1;
    end

    // Fires on the cycle the count would reach 255.
    assign timeout = (wdog_q == 8'd254);

    always_ff @(posedge clk) begin
        if (rst) wdog_q <= 8'd0;
        else     wdog_q <= wdog_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            len_q     <= 8'd0;
            sent_q    <= 8'd0;
            recv_q    <= 8'd0;
            key_cnt_q <= 6'd0;
            dout_a_q  <= 8'd0;
            dout_b_q  <= 8'd0;
            dva_q     <= 1'b0;
            dvb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            len_q     <= len_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            key_cnt_q <= key_cnt_d;
            dout_a_q  <= dout_a_d;
            dout_b_q  <= dout_b_d;
            dva_q     <= dva_d;
            dvb_q     <= dvb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        len_d     = len_q;
        sent_d    = sent_q;
        recv_d    = recv_q;
        key_cnt_d = key_cnt_q;
        dout_a_d  = dout_a_q;
        dout_b_d  = dout_b_q;
        dva_d     = 1'b0;
        dvb_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_a || req_b) begin
                    owner_d = (req_a && req_b) ? prio_q : req_b;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                len_d     = owner_q ? len_b : len_a;
                sent_d    = 8'd0;
                recv_d    = 8'd0;
                key_cnt_d = 6'd0;
                state_d   = S_KEY;
            end
            S_KEY: begin
                key_cnt_d = key_cnt_q + 6'd1;
                if (key_cnt_q == 6'd32) state_d = S_KSA;
            end
            S_KSA: begin
                if (plain_read)   state_d = (len_q == 8'd0) ? S_DONE : S_DATA;
                else if (timeout) state_d = S_ERR;
            end
            S_DATA: begin
                if (beat) begin
                    sent_d = sent_q + 8'd1;
                    if ((sent_q + 8'd1) == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (recv_q == len_q) state_d = S_DONE;
                else if (timeout)    state_d = S_ERR;
            end
            S_DONE, S_ERR: begin
                prio_d  = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            recv_d = recv_q + 8'd1;
            if (owner_q) begin
                dout_b_d = cipher_out;
                dvb_d    = 1'b1;
            end else begin
                dout_a_d = cipher_out;
                dva_d    = 1'b1;
            end
        end
    end

    // Outputs are forced quiet while rst is high, even before the state register clears.
    always_comb begin
        gnt_a          = 1'b0;
        gnt_b          = 1'b0;
        key_addr       = 5'd0;
        din_ack        = 1'b0;
        dout_a         = 8'd0;
        dout_b         = 8'd0;
        dout_valid_a   = 1'b0;
        dout_valid_b   = 1'b0;
        done_a         = 1'b0;
        done_b         = 1'b0;
        err            = 1'b0;
        core_rst       = 1'b1;
        key_valid      = 1'b0;
        key_in         = 8'd0;
        plain_in_valid = 1'b0;
        plain_in       = 8'd0;
        if (!rst) begin
            core_rst = (state_q == S_GRANT);
            if (state_q != S_IDLE) begin
                gnt_a = ~owner_q;
                gnt_b = owner_q;
            end
            key_valid = (state_q == S_KEY);
            if ((state_q == S_KEY) && (key_cnt_q != 6'd0)) begin
                key_addr = 5'(key_cnt_q - 6'd1);
                key_in   = own_key;
            end
            if (state_q == S_DATA) plain_in = own_din;
            plain_in_valid = beat;
            din_ack        = beat;
            dout_a         = dout_a_q;
            dout_b         = dout_b_q;
            dout_valid_a   = dva_q;
            dout_valid_b   = dvb_q;
            done_a         = (state_q == S_DONE) && !owner_q;
            done_b         = (state_q == S_DONE) && owner_q;
`ifdef RC4_ARB_TIMEOUT_EN
            err            = (state_q == S_ERR);
`endif
        end
    end

endmodule

// File: tb/tb_rc4_arbiter.sv
// tb/tb_rc4_arbiter.sv - directed bench for rc4_arbiter with a cipher-byte scoreboard
module tb_rc4_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b;
    logic [7:0] len_a, len_b;
    logic [7:0] key_a, key_b;
    logic [7:0] din_a, din_b;
    logic       din_valid_a, din_valid_b;
    logic       gnt_a, gnt_b;
    logic [4:0] key_addr;
    logic       din_ack;
    logic [7:0] dout_a, dout_b;
    logic       dout_valid_a, dout_valid_b;
    logic       done_a, done_b;
    logic       err;
    logic       core_rst;
    logic       key_valid;
    logic [7:0] key_in;
    logic       plain_in_valid;
    logic [7:0] plain_in;
    logic       plain_read;
    logic       cipher_write;
    logic [7:0] cipher_out;

    always #5 clk = ~clk;

    rc4_arbiter dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .len_a(len_a), .len_b(len_b), .key_a(key_a), .key_b(key_b),
        .din_a(din_a), .din_b(din_b), .din_valid_a(din_valid_a), .din_valid_b(din_valid_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .key_addr(key_addr), .din_ack(din_ack),
        .dout_a(dout_a), .dout_b(dout_b), .dout_valid_a(dout_valid_a), .dout_valid_b(dout_valid_b),
        .done_a(done_a), .done_b(done_b), .err(err), .core_rst(core_rst),
        .key_valid(key_valid), .key_in(key_in), .plain_in_valid(plain_in_valid), .plain_in(plain_in),
        .plain_read(plain_read), .cipher_write(cipher_write), .cipher_out(cipher_out)
    );

    assign key_a = {3'b000, key_addr};
    assign key_b = {3'b000, key_addr} ^ 8'hA0;

    int total = 0;
    int bad   = 0;

    // Monitor-owned tallies and scoreboard queues.
    int kv_cnt = 0, kv_idx = 0, kerr = 0, perr = 0, piv_cnt = 0;
    int dva_cnt = 0, dvb_cnt = 0, done_a_cnt = 0, done_b_cnt = 0, err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] ek, src;
    bit ack_a = 0, ack_b = 0;

    always @(negedge clk) begin
        ack_a = din_ack && gnt_a;
        ack_b = din_ack && gnt_b;
        if (!rst) begin
            if (key_valid) begin
                kv_cnt++;
                if (kv_idx > 0) begin
                    ek = 8'(kv_idx - 1);
                    if (gnt_b) ek = ek ^ 8'hA0;
                    if ((key_addr != 5'(kv_idx - 1)) || (key_in != ek)) kerr++;
                end
                kv_idx++;
            end else begin
                kv_idx = 0;
            end
            if (plain_in_valid) begin
                piv_cnt++;
                src = gnt_b ? din_b : din_a;
                exp_q.push_back(src ^ 8'hC3);
                if (plain_in != src) perr++;
            end
            if (dout_valid_a) begin dva_cnt++; obs_q.push_back(dout_a); end
            if (dout_valid_b) begin dvb_cnt++; obs_q.push_back(dout_b); end
            if (done_a) done_a_cnt++;
            if (done_b) done_b_cnt++;
            if (err)    err_cnt++;
        end
    end

    // Engine model: one-cycle latency, cipher = plain ^ 0xC3; stray injects a bogus write.
    bit         pend = 0, stray = 0;
    logic [7:0] pend_d = 8'd0;
    always @(negedge clk) begin
        pend   = plain_in_valid;
        pend_d = plain_in ^ 8'hC3;
    end
    always @(posedge clk) begin
        #2;
        cipher_write = pend | stray;
        cipher_out   = stray ? 8'hEE : pend_d;
    end

    // Plaintext sources advance on each acknowledged byte, with random valid gaps.
    int a_idx = 0, b_idx = 0;
    always @(posedge clk) begin
        #1;
        if (ack_a) a_idx++;
        if (ack_b) b_idx++;
        din_a       = 8'(8'h30 + a_idx * 7);
        din_b       = 8'(8'h80 + b_idx * 5);
        din_valid_a = ($urandom_range(0, 3) != 0);
        din_valid_b = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int s);
        case (s)
            0: return gnt_a;
            1: return gnt_b;
            2: return done_a;
            3: return done_b;
            default: return key_valid;
        endcase
    endfunction

    task automatic wait_for(input int s, input logic lvl, input int budget, input string tag);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel(s) === lvl) begin ok = 1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic drive();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    int rd = 0;
    task automatic sb_check(input int n, input string tag);
        chk({tag, "_exp_n"}, 32'(exp_q.size() - rd), 32'(n));
        chk({tag, "_obs_n"}, 32'(obs_q.size() - rd), 32'(n));
        for (int i = 0; i < n; i++) begin
            if ((rd < exp_q.size()) && (rd < obs_q.size()))
                chk({tag, "_byte"}, 32'(obs_q[rd]), 32'(exp_q[rd]));
            rd++;
        end
    endtask

    task automatic do_reset();
        drive(); rst = 1;
        drive(); drive(); rst = 0;
    endtask

    int kv0, piv0, dva0, dvb0, da0, db0, er0, n;
    task automatic snap();
        kv0 = kv_cnt; piv0 = piv_cnt; dva0 = dva_cnt; dvb0 = dvb_cnt;
        da0 = done_a_cnt; db0 = done_b_cnt; er0 = err_cnt;
    endtask

    initial begin
        rst = 1; req_a = 0; req_b = 0; len_a = 0; len_b = 0; plain_read = 1;
        cipher_write = 0; cipher_out = 0; din_a = 0; din_b = 0; din_valid_a = 0; din_valid_b = 0;

        // Reset behaviour
        repeat (3) @(negedge clk);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
        drive(); rst = 0;
        @(negedge clk);
        chk("idle_core_rst", 32'(core_rst), 32'd0);
        chk("idle_outs", 32'({gnt_a, gnt_b, key_valid, plain_in_valid, dout_valid_a, dout_valid_b, done_a, done_b, err}), 32'd0);

        // Single A session of 4 bytes; req dropped after grant
        snap(); len_a = 8'd4; req_a = 1;
        wait_for(0, 1'b1, 10, "t1_gnt_a");
        chk("t1_grant_core_rst", 32'(core_rst), 32'd1);
        drive(); req_a = 0; len_a = 8'd99;
        wait_for(2, 1'b1, 300, "t1_done_a");
        settle();
        chk("t1_key_cycles", 32'(kv_cnt - kv0), 32'd33);
        chk("t1_key_bytes", 32'(kerr), 32'd0);
        chk("t1_plain_beats", 32'(piv_cnt - piv0), 32'd4);
        chk("t1_plain_data", 32'(perr), 32'd0);
        chk("t1_dout_a", 32'(dva_cnt - dva0), 32'd4);
        chk("t1_dout_b", 32'(dvb_cnt - dvb0), 32'd0);
        chk("t1_done_a", 32'(done_a_cnt - da0), 32'd1);
        chk("t1_gnt_dropped", 32'(gnt_a), 32'd0);
        sb_check(4, "t1_sb");

        // Simultaneous requests after reset: A first, then B
        do_reset();
        snap(); len_a = 8'd3; len_b = 8'd2; req_a = 1; req_b = 1;
        wait_for(0, 1'b1, 10, "t2_gnt_a");
        chk("t2_gnt_b_low", 32'(gnt_b), 32'd0);
        drive(); req_a = 0;
        wait_for(2, 1'b1, 300, "t2_done_a");
        chk("t2_no_dout_b_yet", 32'(dvb_cnt - dvb0), 32'd0);
        @(negedge clk);
        chk("t2_idle_gap", 32'(gnt_b), 32'd0);
        @(negedge clk);
        chk("t2_gnt_b_next", 32'(gnt_b), 32'd1);
        drive(); req_b = 0;
        wait_for(3, 1'b1, 300, "t2_done_b");
        settle();
        chk("t2_dout_a", 32'(dva_cnt - dva0), 32'd3);
        chk("t2_dout_b", 32'(dvb_cnt - dvb0), 32'd2);
        chk("t2_done_cnt", 32'((done_a_cnt - da0) + (done_b_cnt - db0)), 32'd2);
        sb_check(5, "t2_sb");

        // Stray cipher writes while idle are dropped
        snap(); stray = 1;
        drive(); drive(); stray = 0;
        settle();
        chk("t3_stray_dropped", 32'((dva_cnt - dva0) + (dvb_cnt - dvb0)), 32'd0);

        // Zero-length session on B, KSA held until plain_read
        snap(); plain_read = 0; len_b = 8'd0; req_b = 1;
        wait_for(1, 1'b1, 10, "t4_gnt_b");
        drive(); req_b = 0;
        repeat (60) @(negedge clk);
        chk("t4_ksa_wait_gnt", 32'(gnt_b), 32'd1);
        chk("t4_ksa_wait_no_done", 32'(done_b_cnt - db0), 32'd0);
        drive(); plain_read = 1;
        wait_for(3, 1'b1, 10, "t4_done_b");
        settle();
        chk("t4_key_cycles", 32'(kv_cnt - kv0), 32'd33);
        chk("t4_no_plain", 32'(piv_cnt - piv0), 32'd0);
        chk("t4_no_dout", 32'(dvb_cnt - dvb0), 32'd0);

        // Reset in the middle of an 8-byte DATA phase
        snap(); len_a = 8'd8; req_a = 1;
        wait_for(0, 1'b1, 10, "t5_gnt_a");
        drive(); req_a = 0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((piv_cnt - piv0) >= 2) begin n = 1; break; end
        end
        chk("t5_reach_data", 32'(n), 32'd1);
        drive(); rst = 1;
        @(negedge clk);
        chk("t5_rst_core_rst", 32'(core_rst), 32'd1);
        drive(); rst = 0;
        @(negedge clk);
        chk("t5_outs_zero", 32'({gnt_a, gnt_b, key_valid, plain_in_valid, din_ack, dout_valid_a, dout_valid_b, done_a, done_b, err, core_rst}), 32'd0);
        settle();
        chk("t5_no_done", 32'(done_a_cnt - da0), 32'd0);
        rd = 0; exp_q.delete(); obs_q.delete();
        len_a = 8'd2; req_a = 1;
        wait_for(0, 1'b1, 10, "t5_regrant");
        chk("t5_regrant_core_rst", 32'(core_rst), 32'd1);
        drive(); req_a = 0;
        wait_for(2, 1'b1, 300, "t5_done_after_abort");
        settle();
        sb_check(2, "t5_sb");

        // Engine never ready: watchdog (if built in) or indefinite KSA wait
        snap(); plain_read = 0; len_a = 8'd1; req_a = 1;
        wait_for(0, 1'b1, 10, "t6_gnt_a");
        drive(); req_a = 0;
        wait_for(4, 1'b1, 10, "t6_key_start");
        wait_for(4, 1'b0, 40, "t6_ksa_entry");
`ifdef RC4_ARB_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (err) break;
        end
        chk("t6_err_cycle", 32'(n), 32'd255);
        @(negedge clk);
        chk("t6_gnt_dropped", 32'(gnt_a), 32'd0);
        chk("t6_err_pulse", 32'(err_cnt - er0), 32'd1);
        chk("t6_no_done", 32'(done_a_cnt - da0), 32'd0);
`else
        repeat (300) @(negedge clk);
        chk("t6_stays_ksa", 32'(gnt_a), 32'd1);
        chk("t6_no_err", 32'(err_cnt - er0), 32'd0);
        chk("t6_no_done", 32'(done_a_cnt - da0), 32'd0);
        do_reset();
`endif
        plain_read = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
